regm_wr_arb: RTL and testbench
==============================

Name: regm_wr_arb

Overview:
- Owns the single write port of the 32x32 register file (`regm`) and shares it between two writers:
  - the in-order pipeline writeback stage (WB);
  - a long-latency multiply/divide unit (MDU).
- Buffers one MDU result, arbitrates with a starvation guard, and keeps a pending-write scoreboard so decode can stall reads of registers whose MDU result is outstanding.
- Sits between WB/MDU and `regm`; drives `regm`'s regwrite/wrreg/wrdata.

Parameters:
- STARVE_MAX, 4, max consecutive cycles a held MDU result may lose to WB before it is forced through (1..15).
- DW, 32, data width.
- NREG, 32, register count; index width is 5.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wb_valid  in  1  WB has a result.
- wb_ready  out  1  WB result consumed this cycle; low means pipeline stalls.
- wb_reg  in  5  WB destination register.
- wb_data  in  32  WB data.
- mdu_valid  in  1  MDU has a result.
- mdu_ready  out  1  hold buffer can accept.
- mdu_reg  in  5  MDU destination register.
- mdu_data  in  32  MDU data.
- issue_valid  in  1  decode issues an MDU op.
- issue_reg  in  5  destination of the issued MDU op.
- issue_ready  out  1  issue accepted (destination not already pending).
- rd1_reg  in  5  decode read address 1.
- rd2_reg  in  5  decode read address 2.
- rd1_busy  out  1  rd1_reg has an outstanding MDU write.
- rd2_busy  out  1  rd2_reg has an outstanding MDU write.
- regwrite  out  1  to `regm` regwrite.
- wrreg  out  5  to `regm` wrreg.
- wrdata  out  32  to `regm` wrdata.
- stat_stall  out  32  WB stall-cycle count (see Optional Feature).
- stat_mdu_wr  out  32  MDU write count (see Optional Feature).

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values:
  - State: hold_valid=0, busy[31:0]=0, starve_cnt=0.
  - Outputs while rst=1: regwrite=0, wb_ready=0, mdu_ready=0, issue_ready=0, rd*_busy=0.
  - wrreg/wrdata=0 while rst=1.
- Reset mid-operation: a held MDU result is discarded; all pending bits clear. Upstream must flush.
- Hold buffer:
  - mdu_ready = !hold_valid.
  - On mdu_valid && mdu_ready, capture reg/data; hold_valid=1 next cycle.
  - A result accepted in cycle N is writable no earlier than N+1.
  - No same-cycle refill on drain. Maximum MDU throughput is one result per 2 cycles.
- Grant (combinational from registered hold and current WB inputs):
  - GNT_MDU if hold_valid && (!wb_valid || starve_cnt==STARVE_MAX).
  - else GNT_WB if wb_valid.
  - else GNT_NONE.
- Grant outputs:
  - wb_ready = wb_valid && grant==GNT_WB.
  - Write port carries the granted source's reg/data; wrreg/wrdata=0 on GNT_NONE.
  - regwrite = (grant!=GNT_NONE) && wrreg!=0.
- $zero writes: a grant to $0 still completes the handshake or drains the hold, with regwrite=0.
- hold_valid clears on the cycle after GNT_MDU.
- starve_cnt:
  - +1 (saturating) when hold_valid && grant==GNT_WB.
  - Clears to 0 when hold_valid=0 or grant==GNT_MDU.
- Scoreboard busy[31:0]:
  - issue_ready = issue_reg==0 || !busy[issue_reg].
  - issue_valid && issue_ready && issue_reg!=0 sets busy[issue_reg].
  - GNT_MDU clears busy[hold_reg].
  - Same-register set and clear in one cycle: set wins.
- Read stall outputs:
  - rdX_busy = rdX_reg!=0 && busy[rdX_reg] && !(GNT_MDU && hold_reg==rdX_reg).
  - Same-cycle clear is bypassed because `regm` forwards wrdata to matching reads.
- WB to a busy register is a decode ordering error and is not checked. A simulation-only assertion flags it.

Optional Feature:
- Macro REGM_ARB_STATS_EN.
- Defined:
  - stat_stall increments each cycle wb_valid && !wb_ready.
  - stat_mdu_wr increments per GNT_MDU.
  - Both 32-bit, wrap at 2^32, cleared by rst.
- Undefined: counters are not built; stat_* outputs are tied to 0. Ports are present in both builds.

Decomposition:
- Package regm_pkg holds:
  - regidx_t (logic [4:0]) and word_t (logic [31:0]);
  - REG_ZERO=5'd0;
  - enum grant_t {GNT_NONE, GNT_WB, GNT_MDU}.
- Sub-module regm_scoreboard: busy vector, set/clear/priority, rd1/rd2/issue lookups.
- The arbiter, hold buffer, starve counter and stats stay in regm_wr_arb.

Test Plan:
- Reset: rst=1 with wb_valid=1, wb_reg=8 -> regwrite=0, wb_ready=0. First cycle after rst=0 -> wrreg=8, regwrite=1.
- MDU latency: mdu_valid=1, reg=9, data=0xDEADBEEF in cycle N with WB idle -> cycle N+1 write $t1=0xDEADBEEF; mdu_ready=0 in N+1, 1 in N+2.
- Starvation, STARVE_MAX=4: MDU result held while WB valid every cycle -> WB granted 4 cycles, MDU forced on 5th, wb_ready=0 that cycle, stat_stall=1 (stats build).
- Scoreboard: issue reg 10 -> rd1_reg=10 gives rd1_busy=1. On the MDU write cycle to 10, rd1_busy=0. Re-issue to 10 while busy -> issue_ready=0.
- Set-wins: issue to reg 11 in the same cycle MDU writes reg 11 -> busy[11] remains 1 next cycle.
- $zero: WB to reg 0 -> wb_ready=1, regwrite=0. Issue to reg 0 -> issue_ready=1, no busy bit set. MDU to reg 0 -> hold drains, regwrite=0.

Source files
------------

// File: rtl/regm_pkg.sv
// Shared types for the regm write-port arbiter: register index, data word and grant encoding.
package regm_pkg;

   typedef logic [4:0]  regidx_t;
   typedef logic [31:0] word_t;

   localparam regidx_t REG_ZERO = 5'd0;
   localparam int      STARVE_W = 4;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_WB,
      GNT_MDU
   } grant_t;

endpackage

// File: rtl/regm_scoreboard.sv
// Pending-write scoreboard: one busy bit per register for MDU results still in flight.
// Set on issue, cleared when the MDU result reaches the write port; set wins on collision.
import regm_pkg::*;

module regm_scoreboard #(
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue_valid,
   input  regidx_t         issue_reg,
   output logic            issue_ready,
   input  logic            clr_en,
   input  regidx_t         clr_reg,
   input  regidx_t         rd1_reg,
   input  regidx_t         rd2_reg,
   output logic            rd1_busy,
   output logic            rd2_busy,
   output logic [NREG-1:0] busy_vec
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic            set_en;

   always_comb begin
      issue_ready = !rst && ((issue_reg == REG_ZERO) || !busy_q[issue_reg]);
      set_en      = issue_valid && issue_ready && (issue_reg != REG_ZERO);
   end

   // Clear is applied first so a same-cycle set on the same register survives.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) begin
         busy_d[clr_reg] = 1'b0;
      end
      if (set_en) begin
         busy_d[issue_reg] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // A register being written this cycle is not reported busy: regm forwards wrdata to reads.
   always_comb begin
      rd1_busy = !rst && (rd1_reg != REG_ZERO) && busy_q[rd1_reg] &&
                 !(clr_en && (clr_reg == rd1_reg));
      rd2_busy = !rst && (rd2_reg != REG_ZERO) && busy_q[rd2_reg] &&
                 !(clr_en && (clr_reg == rd2_reg));
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/regm_wr_arb.sv
// Write-port arbiter for regm: shares the single write port between WB and a buffered MDU result.
// Define REGM_ARB_STATS_EN to build the stat_stall / stat_mdu_wr counters (tied to 0 otherwise).
import regm_pkg::*;

module regm_wr_arb #(
   parameter int STARVE_MAX = 4,
   parameter int DW         = 32,
   parameter int NREG       = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wb_valid,
   output logic          wb_ready,
   input  logic [4:0]    wb_reg,
   input  logic [DW-1:0] wb_data,
   input  logic          mdu_valid,
   output logic          mdu_ready,
   input  logic [4:0]    mdu_reg,
   input  logic [DW-1:0] mdu_data,
   input  logic          issue_valid,
   input  logic [4:0]    issue_reg,
   output logic          issue_ready,
   input  logic [4:0]    rd1_reg,
   input  logic [4:0]    rd2_reg,
   output logic          rd1_busy,
   output logic          rd2_busy,
   output logic          regwrite,
   output logic [4:0]    wrreg,
   output logic [DW-1:0] wrdata,
   output logic [31:0]   stat_stall,
   output logic [31:0]   stat_mdu_wr
);

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   logic                hold_valid_q, hold_valid_d;
   regidx_t             hold_reg_q, hold_reg_d;
   logic [DW-1:0]       hold_data_q, hold_data_d;
   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
   grant_t              grant;
   logic [NREG-1:0]     busy_vec;

   always_comb begin
      grant = GNT_NONE;
      if (!rst) begin
         if (hold_valid_q && (!wb_valid || (starve_cnt_q == STARVE_LIM))) begin
            grant = GNT_MDU;
         end else if (wb_valid) begin
            grant = GNT_WB;
         end
      end
   end

   always_comb begin
      wb_ready  = wb_valid && (grant == GNT_WB);
      mdu_ready = !rst && !hold_valid_q;
      wrreg     = REG_ZERO;
      wrdata    = '0;
      case (grant)
         GNT_WB: begin
            wrreg  = wb_reg;
            wrdata = wb_data;
         end
         GNT_MDU: begin
            wrreg  = hold_reg_q;
            wrdata = hold_data_q;
         end
         default: ;
      endcase
      regwrite = (grant != GNT_NONE) && (wrreg != REG_ZERO);
   end

   // Capture only into an empty buffer, so a drain and a refill never share a cycle.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_reg_d   = hold_reg_q;
      hold_data_d  = hold_data_q;
      if (grant == GNT_MDU) begin
         hold_valid_d = 1'b0;
      end
      if (mdu_valid && mdu_ready) begin
         hold_valid_d = 1'b1;
         hold_reg_d   = mdu_reg;
         hold_data_d  = mdu_data;
      end
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!hold_valid_q || (grant == GNT_MDU)) begin
         starve_cnt_d = '0;
      end else if ((grant == GNT_WB) && (starve_cnt_q != STARVE_LIM)) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid_q <= 1'b0;
         starve_cnt_q <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         starve_cnt_q <= starve_cnt_d;
      end
      hold_reg_q  <= hold_reg_d;
      hold_data_q <= hold_data_d;
   end

   regm_scoreboard #(
      .NREG (NREG)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_reg   (issue_reg),
      .issue_ready (issue_ready),
      .clr_en      (grant == GNT_MDU),
      .clr_reg     (hold_reg_q),
      .rd1_reg     (rd1_reg),
      .rd2_reg     (rd2_reg),
      .rd1_busy    (rd1_busy),
      .rd2_busy    (rd2_busy),
      .busy_vec    (busy_vec)
   );

`ifdef REGM_ARB_STATS_EN
   logic [31:0] stat_stall_q, stat_stall_d;
   logic [31:0] stat_mdu_wr_q, stat_mdu_wr_d;

   always_comb begin
      stat_stall_d  = stat_stall_q;
      stat_mdu_wr_d = stat_mdu_wr_q;
      if (wb_valid && !wb_ready) begin
         stat_stall_d = stat_stall_q + 32'd1;
      end
      if (grant == GNT_MDU) begin
         stat_mdu_wr_d = stat_mdu_wr_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_stall_q  <= '0;
         stat_mdu_wr_q <= '0;
      end else begin
         stat_stall_q  <= stat_stall_d;
         stat_mdu_wr_q <= stat_mdu_wr_d;
      end
   end

   assign stat_stall  = stat_stall_q;
   assign stat_mdu_wr = stat_mdu_wr_q;
`else
   assign stat_stall  = '0;
   assign stat_mdu_wr = '0;
`endif

`ifndef SYNTHESIS
   // Decode must never let WB target a register with an MDU result still outstanding.
   wb_to_busy_reg : assert property (@(posedge clk) disable iff (rst)
      !(wb_ready && (wb_reg != REG_ZERO) && busy_vec[wb_reg]));
`endif

endmodule

// File: tb/tb_regm_wr_arb.sv
// Directed bench for regm_wr_arb: reset, MDU latency, starvation, scoreboard, set-wins, $zero, mid-op reset.
module tb_regm_wr_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid, wb_ready;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        mdu_valid, mdu_ready;
   logic [4:0]  mdu_reg;
   logic [31:0] mdu_data;
   logic        issue_valid, issue_ready;
   logic [4:0]  issue_reg;
   logic [4:0]  rd1_reg, rd2_reg;
   logic        rd1_busy, rd2_busy;
   logic        regwrite;
   logic [4:0]  wrreg;
   logic [31:0] wrdata;
   logic [31:0] stat_stall, stat_mdu_wr;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   regm_wr_arb #(
      .STARVE_MAX (4),
      .DW         (32),
      .NREG       (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_reg      (wb_reg),
      .wb_data     (wb_data),
      .mdu_valid   (mdu_valid),
      .mdu_ready   (mdu_ready),
      .mdu_reg     (mdu_reg),
      .mdu_data    (mdu_data),
      .issue_valid (issue_valid),
      .issue_reg   (issue_reg),
      .issue_ready (issue_ready),
      .rd1_reg     (rd1_reg),
      .rd2_reg     (rd2_reg),
      .rd1_busy    (rd1_busy),
      .rd2_busy    (rd2_busy),
      .regwrite    (regwrite),
      .wrreg       (wrreg),
      .wrdata      (wrdata),
      .stat_stall  (stat_stall),
      .stat_mdu_wr (stat_mdu_wr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_valid    = 1'b0;
      wb_reg      = 5'd0;
      wb_data     = 32'd0;
      mdu_valid   = 1'b0;
      mdu_reg     = 5'd0;
      mdu_data    = 32'd0;
      issue_valid = 1'b0;
      issue_reg   = 5'd0;
      rd1_reg     = 5'd0;
      rd2_reg     = 5'd0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      tick();
      tick();

      // Reset with WB already presenting a result
      wb_valid = 1'b1; wb_reg = 5'd8; wb_data = 32'h0000_1234;
      #1;
      chk("rst_regwrite", 32'(regwrite), 32'd0);
      chk("rst_wb_ready", 32'(wb_ready), 32'd0);
      chk("rst_mdu_ready", 32'(mdu_ready), 32'd0);
      chk("rst_issue_ready", 32'(issue_ready), 32'd0);
      chk("rst_wrreg", 32'(wrreg), 32'd0);
      chk("rst_wrdata", wrdata, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_wrreg", 32'(wrreg), 32'd8);
      chk("post_rst_regwrite", 32'(regwrite), 32'd1);
      chk("post_rst_wb_ready", 32'(wb_ready), 32'd1);
      chk("post_rst_wrdata", wrdata, 32'h0000_1234);
      chk("post_rst_mdu_ready", 32'(mdu_ready), 32'd1);

      // MDU latency: accepted in N, written in N+1, buffer free again in N+2
      tick();
      idle();
      mdu_valid = 1'b1; mdu_reg = 5'd9; mdu_data = 32'hDEAD_BEEF;
      #1;
      chk("mdu_n_ready", 32'(mdu_ready), 32'd1);
      chk("mdu_n_regwrite", 32'(regwrite), 32'd0);
      tick();
      mdu_valid = 1'b0;
      #1;
      chk("mdu_n1_regwrite", 32'(regwrite), 32'd1);
      chk("mdu_n1_wrreg", 32'(wrreg), 32'd9);
      chk("mdu_n1_wrdata", wrdata, 32'hDEAD_BEEF);
      chk("mdu_n1_ready", 32'(mdu_ready), 32'd0);
      tick();
      #1;
      chk("mdu_n2_ready", 32'(mdu_ready), 32'd1);
      chk("mdu_n2_regwrite", 32'(regwrite), 32'd0);

      // Starvation: WB wins 4 times, then the held result is forced through
      wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'h55;
      mdu_valid = 1'b1; mdu_reg = 5'd12; mdu_data = 32'h00C0_FFEE;
      #1;
      chk("starve_capture_wb", 32'(wb_ready), 32'd1);
      tick();
      mdu_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("starve_wb_win%0d", i), 32'(wb_ready), 32'd1);
         chk($sformatf("starve_wrreg%0d", i), 32'(wrreg), 32'd5);
         tick();
      end
      #1;
      chk("starve_forced_wb_ready", 32'(wb_ready), 32'd0);
      chk("starve_forced_wrreg", 32'(wrreg), 32'd12);
      chk("starve_forced_wrdata", wrdata, 32'h00C0_FFEE);
      chk("starve_forced_regwrite", 32'(regwrite), 32'd1);
      tick();
      #1;
      chk("starve_after_wb_ready", 32'(wb_ready), 32'd1);
      chk("starve_after_mdu_ready", 32'(mdu_ready), 32'd1);
`ifdef REGM_ARB_STATS_EN
      chk("stat_stall", stat_stall, 32'd1);
      chk("stat_mdu_wr", stat_mdu_wr, 32'd2);
`else
      chk("stat_stall_tied", stat_stall, 32'd0);
      chk("stat_mdu_wr_tied", stat_mdu_wr, 32'd0);
`endif

      // Scoreboard: issue, lookup, re-issue blocked, bypass on the write cycle
      tick();
      idle();
      issue_valid = 1'b1; issue_reg = 5'd10;
      #1;
      chk("sb_issue_ready", 32'(issue_ready), 32'd1);
      tick();
      rd1_reg = 5'd10; rd2_reg = 5'd3;
      #1;
      chk("sb_rd1_busy", 32'(rd1_busy), 32'd1);
      chk("sb_rd2_free", 32'(rd2_busy), 32'd0);
      chk("sb_reissue_blocked", 32'(issue_ready), 32'd0);
      tick();
      issue_valid = 1'b0;
      mdu_valid = 1'b1; mdu_reg = 5'd10; mdu_data = 32'hA5A5_0010;
      #1;
      chk("sb_busy_while_accept", 32'(rd1_busy), 32'd1);
      tick();
      mdu_valid = 1'b0;
      #1;
      chk("sb_write_cycle_wrreg", 32'(wrreg), 32'd10);
      chk("sb_write_cycle_bypass", 32'(rd1_busy), 32'd0);
      tick();
      #1;
      chk("sb_cleared_rd1", 32'(rd1_busy), 32'd0);
      chk("sb_cleared_issue_ready", 32'(issue_ready), 32'd1);

      // Set-wins: issue 11 on the cycle the MDU writes 11
      idle();
      mdu_valid = 1'b1; mdu_reg = 5'd11; mdu_data = 32'h11;
      tick();
      mdu_valid = 1'b0;
      issue_valid = 1'b1; issue_reg = 5'd11; rd2_reg = 5'd11;
      #1;
      chk("sw_issue_ready", 32'(issue_ready), 32'd1);
      chk("sw_wrreg", 32'(wrreg), 32'd11);
      chk("sw_rd2_before", 32'(rd2_busy), 32'd0);
      tick();
      issue_valid = 1'b0;
      #1;
      chk("sw_busy_kept", 32'(rd2_busy), 32'd1);

      // $zero handling for WB, issue and MDU
      tick();
      idle();
      wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'hFF;
      issue_valid = 1'b1; issue_reg = 5'd0;
      #1;
      chk("zero_wb_ready", 32'(wb_ready), 32'd1);
      chk("zero_wb_regwrite", 32'(regwrite), 32'd0);
      chk("zero_issue_ready", 32'(issue_ready), 32'd1);
      tick();
      idle();
      rd1_reg = 5'd0;
      mdu_valid = 1'b1; mdu_reg = 5'd0; mdu_data = 32'h77;
      #1;
      chk("zero_rd1_busy", 32'(rd1_busy), 32'd0);
      chk("zero_mdu_ready", 32'(mdu_ready), 32'd1);
      tick();
      mdu_valid = 1'b0;
      #1;
      chk("zero_mdu_regwrite", 32'(regwrite), 32'd0);
      chk("zero_mdu_held", 32'(mdu_ready), 32'd0);
      tick();
      #1;
      chk("zero_mdu_drained", 32'(mdu_ready), 32'd1);

      // Reset mid-operation discards the held result and pending bits
      mdu_valid = 1'b1; mdu_reg = 5'd13; mdu_data = 32'h1313;
      tick();
      mdu_valid = 1'b0;
      rst = 1'b1;
      rd2_reg = 5'd11;
      #1;
      chk("midrst_regwrite", 32'(regwrite), 32'd0);
      chk("midrst_mdu_ready", 32'(mdu_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("midrst_hold_dropped", 32'(mdu_ready), 32'd1);
      chk("midrst_no_write", 32'(regwrite), 32'd0);
      chk("midrst_busy_cleared", 32'(rd2_busy), 32'd0);

      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
